lcd_scanout: RTL and testbench
==============================

# lcd_scanout

Display-side reader of the 160x144, 2-bit-per-pixel LCD framebuffer that the PPU mode-3 renderer fills through `lcd_a`/`lcd_wr`.
- Generates 640x480 VGA-style timing on a pixel-clock enable.
- Fetches framebuffer shades with integer 3x upscaling, centred in the active area with a black border.
- Maps each shade to a 12-bit RGB colour.
- Sits between the framebuffer BRAM read port and the board video output.

## Interface
- `H_ACTIVE`, 640, visible columns; `H_FP` 16, `H_SYNC` 96, `H_BP` 48 (total 800)
- `V_ACTIVE`, 480, visible lines; `V_FP` 10, `V_SYNC` 2, `V_BP` 33 (total 525)
- `SCALE`, 3, replication factor in both axes
- `X_OFF`, 80, first image column; `Y_OFF`, 24, first image line
- `FB_W`, 160, `FB_H`, 144, framebuffer dimensions
- `clk` in 1: single clock, all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pix_en` in 1: pixel strobe; counters and pipeline advance only when high.
- `fb_a` out 16: framebuffer read address, x + 160*y.
- `fb_rd` out 1: read enable, high when `fb_a` is a new valid fetch.
- `fb_dout` in 2: shade from the synchronous BRAM, valid one `clk` after `fb_a`/`fb_rd`.
- `hsync`, `vsync` out 1: active-low syncs, pipeline-aligned with `rgb`.
- `de` out 1: active-area flag, aligned with `rgb`.
- `rgb` out 12: {R4,G4,B4}.
- `vblank` out 1: high while the line counter ≥ `V_ACTIVE`, unaligned; the renderer may write without tearing.
- `frame_start` out 1: one-`clk` pulse on the `pix_en` where the counters wrap to (0,0).

## Operation
- **Timing counters `hc`/`vc`.**
  - On `pix_en`, `hc` increments.
  - At 799 `hc` wraps to 0 and `vc` increments.
  - At 524 `vc` wraps to 0.
- **Raw signals, derived from `hc`/`vc`.**
  - `de_raw` = `hc`<640 && `vc`<480.
  - `hs_raw` low for `hc` in [656,751].
  - `vs_raw` low for `vc` in [490,491].
  - `img_raw` = `hc` in [80,559] && `vc` in [24,455].
- **Address generation, no divider.**
  - Column sub-counter `csub` (0..2) and column `sx` (0..159).
  - Row sub-counter `rsub` (0..2) and row base `rbase` (0, 160, … 22880).
  - Within image columns, each `pix_en` increments `csub`; on 2→0 `sx` increments.
  - At `hc`=559, `csub` and `sx` clear.
  - At end of each image line (`hc`=799, `vc` in [24,455]), `rsub` increments; on 2→0 `rbase` += 160.
  - At `vc`=524 wrap, `rsub` and `rbase` clear.
- **Stage 1, on each `pix_en`.**
  - `fb_a` <= `rbase` + `sx`.
  - `fb_rd` <= `img_raw`.
  - `img1`, `de1`, `hs1`, `vs1` are registered.
  - `fb_rd` deasserts on the next `clk` if `pix_en` is low.
  - `fb_a` holds its value outside the image.
- **Stage 2, on each `pix_en`.**
  - `hsync`, `vsync`, `de` <= stage-1 copies.
  - `rgb` <= `img1` ? `pal(fb_dout)` : 12'h000.
  - `rgb` is also forced to 0 when `de1`=0.
- **Palette.**
  - 0 → 12'hEFD
  - 1 → 12'h9B7
  - 2 → 12'h465
  - 3 → 12'h132
- **Reset values, all outputs and state.**
  - Counters, sub-counters, `rbase`, `fb_a`: 0.
  - `fb_rd`, `de`, `frame_start`: 0.
  - `hsync`, `vsync`: 1.
  - `rgb`: 0.
  - `vblank`: 0 (follows `vc` afterwards).
- **Reset mid-frame.** All state returns to reset values immediately. The first `pix_en` after release begins at `hc`=0, `vc`=0 and pulses `frame_start`.

## Timing
- Output latency is 2 `pix_en` strobes from counter value to `rgb`/`hsync`/`vsync`/`de`. Syncs and `de` are delayed identically, so relative alignment is exact.
- BRAM contract: `fb_dout` is sampled on the `pix_en` after the fetch. Any `pix_en` spacing ≥1 `clk`, including continuous, is legal.
- `pix_en` low: every register except `frame_start`/`fb_rd` holds. Outputs are stable.
- `frame_start` is asserted for the single `clk` of the `pix_en` where `hc`=799 and `vc`=524 wrap. It is 0 otherwise.
- Boundary requirements:
  - Last fetch is `fb_a`=23039 at `hc`=559, `vc`=455.
  - No fetch occurs at `hc`=560 or `vc`=456.
  - `sx` never exceeds 159. `rbase` never exceeds 22880.

## Test plan
- **Reset mid-line.** Drive `rst_n`=0 at `hc`=300, `vc`=100.
  - During reset: `hsync`=`vsync`=1, `de`=0, `rgb`=0, `fb_rd`=0.
  - After release: first `pix_en` pulses `frame_start`.
- **Timing counts.** Continuous `pix_en` for 2 frames.
  - `hsync` low 96 of every 800 strobes.
  - `vsync` low 2 lines of every 525.
  - `de` high for 640x480 strobes per frame.
- **First and last fetch.**
  - At (`hc` 80, `vc` 24): `fb_rd`=1, `fb_a`=0.
  - Address 1 first appears at `hc`=83.
  - Line `vc`=27 starts at `fb_a`=160.
  - Last fetch at (559, 455) is `fb_a`=23039.
- **Shade mapping.** Model framebuffer holds shades 0..3 at addresses 0..3.
  - `rgb` sequence: EFD×3, 9B7×3, 465×3, 132×3, starting 2 strobes after `hc`=80.
  - Border pixels read 000.
- **Sparse strobe.** `pix_en` every 4th `clk`. Per-strobe outputs must be identical to the continuous-strobe run.
- **`vblank`.** `vblank` rises at `vc`=480 and falls at the `vc`=0 wrap.

Source files
------------

// File: rtl/lcd_scanout.sv
// lcd_scanout: VGA-timed scan-out of the 2bpp LCD framebuffer with integer
// upscaling, centred in the active area behind a black border.
module lcd_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 3,
  parameter int X_OFF    = 80,
  parameter int Y_OFF    = 24,
  parameter int FB_W     = 160,
  parameter int FB_H     = 144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [15:0] fb_a,
  output logic        fb_rd,
  input  logic [1:0]  fb_dout,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int SXW     = (FB_W > 1) ? $clog2(FB_W) : 1;

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HCW-1:0] IX_BEG = HCW'(X_OFF);
  localparam logic [HCW-1:0] IX_END = HCW'(X_OFF + SCALE * FB_W - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_BEG = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VCW-1:0] IY_BEG = VCW'(Y_OFF);
  localparam logic [VCW-1:0] IY_END = VCW'(Y_OFF + SCALE * FB_H - 1);
  localparam logic [SW-1:0]  SUB_LAST = SW'(SCALE - 1);
  localparam logic [15:0]    ROW_STEP = 16'(FB_W);

  function automatic logic [11:0] pal(input logic [1:0] shade);
    logic [11:0] c;
    case (shade)
      2'd0:    c = 12'hEFD;
      2'd1:    c = 12'h9B7;
      2'd2:    c = 12'h465;
      2'd3:    c = 12'h132;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  logic [HCW-1:0] hc_r, hc_nxt_s;
  logic [VCW-1:0] vc_r, vc_nxt_s;
  logic [SW-1:0]  csub_r, csub_nxt_s, rsub_r, rsub_nxt_s;
  logic [SXW-1:0] sx_r, sx_nxt_s;
  logic [15:0]    rbase_r, rbase_nxt_s;
  logic           first_r;
  logic           img1_r, de1_r, hs1_r, vs1_r;

  logic h_wrap_s, v_wrap_s, ix_s, iy_s;
  logic de_raw_s, hs_raw_s, vs_raw_s, img_raw_s;

  // Raw timing flags decoded from the current counter values
  always_comb begin
    h_wrap_s  = (hc_r == H_LAST);
    v_wrap_s  = h_wrap_s && (vc_r == V_LAST);
    ix_s      = (hc_r >= IX_BEG) && (hc_r <= IX_END);
    iy_s      = (vc_r >= IY_BEG) && (vc_r <= IY_END);
    de_raw_s  = (hc_r < H_ACT) && (vc_r < V_ACT);
    hs_raw_s  = !((hc_r >= HS_BEG) && (hc_r <= HS_END));
    vs_raw_s  = !((vc_r >= VS_BEG) && (vc_r <= VS_END));
    img_raw_s = ix_s && iy_s;
  end

  // Next-state for timing counters and the divider-free address walkers
  always_comb begin
    hc_nxt_s    = hc_r;
    vc_nxt_s    = vc_r;
    csub_nxt_s  = csub_r;
    sx_nxt_s    = sx_r;
    rsub_nxt_s  = rsub_r;
    rbase_nxt_s = rbase_r;
    if (pix_en) begin
      if (h_wrap_s) begin
        hc_nxt_s = '0;
        if (v_wrap_s) begin
          vc_nxt_s = '0;
        end else begin
          vc_nxt_s = vc_r + VCW'(1);
        end
      end else begin
        hc_nxt_s = hc_r + HCW'(1);
      end

      if (hc_r == IX_END) begin
        csub_nxt_s = '0;
        sx_nxt_s   = '0;
      end else if (ix_s) begin
        if (csub_r == SUB_LAST) begin
          csub_nxt_s = '0;
          sx_nxt_s   = sx_r + SXW'(1);
        end else begin
          csub_nxt_s = csub_r + SW'(1);
        end
      end else begin
        csub_nxt_s = csub_r;
      end

      // Clearing on the last image line keeps rbase inside the framebuffer
      if (v_wrap_s) begin
        rsub_nxt_s  = '0;
        rbase_nxt_s = 16'h0000;
      end else if (h_wrap_s && iy_s) begin
        if (vc_r == IY_END) begin
          rsub_nxt_s  = '0;
          rbase_nxt_s = 16'h0000;
        end else if (rsub_r == SUB_LAST) begin
          rsub_nxt_s  = '0;
          rbase_nxt_s = rbase_r + ROW_STEP;
        end else begin
          rsub_nxt_s = rsub_r + SW'(1);
        end
      end else begin
        rsub_nxt_s = rsub_r;
      end
    end else begin
      hc_nxt_s = hc_r;
    end
  end

  // Counter and address-walker state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_r    <= '0;
      vc_r    <= '0;
      csub_r  <= '0;
      sx_r    <= '0;
      rsub_r  <= '0;
      rbase_r <= 16'h0000;
    end else begin
      hc_r    <= hc_nxt_s;
      vc_r    <= vc_nxt_s;
      csub_r  <= csub_nxt_s;
      sx_r    <= sx_nxt_s;
      rsub_r  <= rsub_nxt_s;
      rbase_r <= rbase_nxt_s;
    end
  end

  // Stage 1 fetch/raw flags and stage 2 palette with aligned syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_a   <= 16'h0000;
      img1_r <= 1'b0;
      de1_r  <= 1'b0;
      hs1_r  <= 1'b1;
      vs1_r  <= 1'b1;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      de     <= 1'b0;
      rgb    <= 12'h000;
    end else if (pix_en) begin
      if (img_raw_s) begin
        fb_a <= rbase_r + 16'(sx_r);
      end
      img1_r <= img_raw_s;
      de1_r  <= de_raw_s;
      hs1_r  <= hs_raw_s;
      vs1_r  <= vs_raw_s;
      hsync  <= hs1_r;
      vsync  <= vs1_r;
      de     <= de1_r;
      rgb    <= (img1_r && de1_r) ? pal(fb_dout) : 12'h000;
    end
  end

  // Single-clk strobes; the first strobe after reset counts as a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_rd       <= 1'b0;
      frame_start <= 1'b0;
      first_r     <= 1'b1;
      vblank      <= 1'b0;
    end else begin
      fb_rd       <= pix_en && img_raw_s;
      frame_start <= pix_en && (v_wrap_s || first_r);
      first_r     <= pix_en ? 1'b0 : first_r;
      vblank      <= (vc_nxt_s >= V_ACT);
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: a full-size instance for line-level address checks and
// a reduced-geometry instance for whole-frame counts, sparse strobes and reset.
module tb_lcd_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pe;
  bit   sel;
  logic pe_a, pe_b;
  assign pe_a = pe & ~sel;
  assign pe_b = pe & sel;

  logic [15:0] fa_a, fa_b;
  logic        rd_a, rd_b, hs_a, hs_b, vs_a, vs_b, de_a, de_b, vb_a, vb_b, fs_a, fs_b;
  logic [1:0]  dout_a = 2'd0, dout_b = 2'd0;
  logic [11:0] rgb_a, rgb_b;

  lcd_scanout u_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pe_a), .fb_a(fa_a), .fb_rd(rd_a), .fb_dout(dout_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a), .vblank(vb_a), .frame_start(fs_a)
  );

  lcd_scanout #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SCALE(3), .X_OFF(8), .Y_OFF(3), .FB_W(8), .FB_H(8)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pe_b), .fb_a(fa_b), .fb_rd(rd_b), .fb_dout(dout_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b), .vblank(vb_b), .frame_start(fs_b)
  );

  // Framebuffer: data for an address issued after one edge is ready by the next
  logic [1:0] mem [0:23039];
  always @(negedge clk) if (rd_a) dout_a <= mem[fa_a];
  always @(negedge clk) if (rd_b) dout_b <= mem[fa_b];

  logic [15:0] o_fa;
  logic        o_rd, o_hs, o_vs, o_de, o_vb, o_fs;
  logic [11:0] o_rgb;
  assign o_fa  = sel ? fa_b  : fa_a;
  assign o_rd  = sel ? rd_b  : rd_a;
  assign o_hs  = sel ? hs_b  : hs_a;
  assign o_vs  = sel ? vs_b  : vs_a;
  assign o_de  = sel ? de_b  : de_a;
  assign o_vb  = sel ? vb_b  : vb_a;
  assign o_fs  = sel ? fs_b  : fs_a;
  assign o_rgb = sel ? rgb_b : rgb_a;

  typedef struct {
    int h; int v;
    logic hs; logic vs; logic de; logic img;
    int addr;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    int h; int v;
    logic exp_rd;
    int exp_a;
  } pt_t;

  localparam int REC = 2100;

  int   n_tests, n_fail;
  int   hact, hfp, hsy, hbp, vact, vfp, vsy, vbp, sc, xo, yo, fw, fh, htot, vtot;
  int   mh, mv, exp_fa, rec_i, rec_mode;
  bit   m_first, stat_on;
  int   st_hs, st_vs, st_de, st_rd, st_fs, st_vb, st_maxa;
  exp_t q[$];
  logic [32:0] rec_w [0:REC-1];
  logic [11:0] shade_seq [0:3];
  pt_t  tbl [0:10];

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (inst %0d, model h=%0d v=%0d)",
               name, act, req, sel, mh, mv);
    end
  endtask

  task automatic set_geom(input bit s);
    if (!s) begin
      hact = 640; hfp = 16; hsy = 96; hbp = 48; vact = 480; vfp = 10; vsy = 2; vbp = 33;
      sc = 3; xo = 80; yo = 24; fw = 160; fh = 144;
    end else begin
      hact = 40; hfp = 4; hsy = 6; hbp = 6; vact = 30; vfp = 2; vsy = 2; vbp = 3;
      sc = 3; xo = 8; yo = 3; fw = 8; fh = 8;
    end
    htot = hact + hfp + hsy + hbp;
    vtot = vact + vfp + vsy + vbp;
  endtask

  function automatic logic [11:0] pal_m(input logic [1:0] s);
    case (s)
      2'd0:    return 12'hEFD;
      2'd1:    return 12'h9B7;
      2'd2:    return 12'h465;
      default: return 12'h132;
    endcase
  endfunction

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    e.h   = h;
    e.v   = v;
    e.hs  = !(h >= hact + hfp && h < hact + hfp + hsy);
    e.vs  = !(v >= vact + vfp && v < vact + vfp + vsy);
    e.de  = (h < hact) && (v < vact);
    e.img = (h >= xo) && (h < xo + sc * fw) && (v >= yo) && (v < yo + sc * fh);
    e.addr = e.img ? ((h - xo) / sc + fw * ((v - yo) / sc)) : 0;
    e.rgb = (e.img && e.de) ? pal_m(mem[e.addr]) : 12'h000;
    return e;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; m_first = 1'b1; exp_fa = 0; rec_i = 0;
    q.delete();
  endtask

  task automatic do_reset_check();
    @(negedge clk);
    pe = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_hsync", o_hs, 1);
    chk("rst_vsync", o_vs, 1);
    chk("rst_de", o_de, 0);
    chk("rst_rgb", o_rgb, 0);
    chk("rst_fb_rd", o_rd, 0);
    chk("rst_fb_a", o_fa, 0);
    chk("rst_frame_start", o_fs, 0);
    chk("rst_vblank", o_vb, 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic strobe(input int gap);
    exp_t e, o;
    logic [32:0] w;
    e = model(mh, mv);
    @(negedge clk);
    pe = 1'b1;
    @(posedge clk); #1;
    q.push_back(e);
    if (q.size() > 1) begin
      o = q.pop_front();
      chk("hsync", o_hs, o.hs);
      chk("vsync", o_vs, o.vs);
      chk("de", o_de, o.de);
      chk("rgb", o_rgb, o.rgb);
      if (!sel && o.v == 24 && o.h >= 80 && o.h <= 91)
        chk("shade_seq", o_rgb, shade_seq[(o.h - 80) / 3]);
    end
    chk("fb_rd", o_rd, e.img);
    if (e.img) exp_fa = e.addr;
    chk("fb_a", o_fa, exp_fa);
    chk("frame_start", o_fs, m_first || (mh == htot - 1 && mv == vtot - 1));
    m_first = 1'b0;
    if (mh == htot - 1) begin
      mh = 0;
      mv = (mv == vtot - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    chk("vblank", o_vb, mv >= vact);
    if (stat_on) begin
      st_hs += !o_hs; st_vs += !o_vs; st_de += o_de; st_rd += o_rd;
      st_fs += o_fs;  st_vb += o_vb;
      if (o_rd && int'(o_fa) > st_maxa) st_maxa = o_fa;
    end
    w = {o_hs, o_vs, o_de, o_rd, o_fs, o_rgb, o_fa};
    if (rec_mode == 1 && rec_i < REC) begin
      rec_w[rec_i] = w;
    end else if (rec_mode == 2 && rec_i < REC) begin
      chk("sparse_ctl", w[32:28], rec_w[rec_i][32:28]);
      chk("sparse_rgb", w[27:16], rec_w[rec_i][27:16]);
      chk("sparse_fa", w[15:0], rec_w[rec_i][15:0]);
    end
    rec_i++;
    if (gap > 1) begin
      @(negedge clk);
      pe = 1'b0;
      for (int i = 1; i < gap; i++) begin
        @(posedge clk); #1;
        chk("fb_rd_idle", o_rd, 0);
        chk("frame_start_idle", o_fs, 0);
      end
    end
  endtask

  task automatic run_to(input int h, input int v, input int gap);
    int n;
    n = 0;
    while (!(mh == h && mv == v)) begin
      strobe(gap);
      n++;
      if (n > htot * vtot) begin
        n_tests++;
        n_fail++;
        $display("FAIL run_to: position (%0d,%0d) not reached within %0d strobes", h, v, n);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    pe = 1'b0; sel = 1'b0; rst_n = 1'b0;
    rec_mode = 0; stat_on = 1'b0;
    st_hs = 0; st_vs = 0; st_de = 0; st_rd = 0; st_fs = 0; st_vb = 0; st_maxa = 0;
    for (int i = 0; i < 23040; i++) mem[i] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 4; i++) mem[i] = 2'(i);
    shade_seq[0] = 12'hEFD; shade_seq[1] = 12'h9B7;
    shade_seq[2] = 12'h465; shade_seq[3] = 12'h132;
    tbl[0]  = '{79, 24, 1'b0, 0};
    tbl[1]  = '{80, 24, 1'b1, 0};
    tbl[2]  = '{82, 24, 1'b1, 0};
    tbl[3]  = '{83, 24, 1'b1, 1};
    tbl[4]  = '{559, 24, 1'b1, 159};
    tbl[5]  = '{560, 24, 1'b0, 159};
    tbl[6]  = '{80, 26, 1'b1, 0};
    tbl[7]  = '{80, 27, 1'b1, 160};
    tbl[8]  = '{85, 27, 1'b1, 161};
    tbl[9]  = '{559, 29, 1'b1, 319};
    tbl[10] = '{560, 29, 1'b0, 319};

    // Full-size geometry: address walk across the first image lines
    set_geom(1'b0);
    repeat (3) @(posedge clk);
    do_reset_check();
    for (int i = 0; i <= 10; i++) begin
      run_to(tbl[i].h, tbl[i].v, 1);
      strobe(1);
      chk("tbl_fb_rd", o_rd, tbl[i].exp_rd);
      chk("tbl_fb_a", o_fa, tbl[i].exp_a);
    end

    // Reduced geometry: two continuous frames with whole-frame counts
    sel = 1'b1;
    set_geom(1'b1);
    do_reset_check();
    rec_mode = 1;
    for (int i = 0; i < 2 * htot * vtot + 2; i++) begin
      stat_on = (i >= 1) && (i <= 2 * htot * vtot);
      strobe(1);
    end
    stat_on = 1'b0;
    chk("cnt_hsync_low", st_hs, 2 * vtot * hsy);
    chk("cnt_vsync_low", st_vs, 2 * htot * vsy);
    chk("cnt_de_high", st_de, 2 * hact * vact);
    chk("cnt_fetches", st_rd, 2 * sc * sc * fw * fh);
    chk("cnt_frame_start", st_fs, 2);
    chk("cnt_vblank", st_vb, 2 * htot * (vtot - vact));
    chk("last_fetch_addr", st_maxa, fw * fh - 1);

    // Reset inside the image, then replay with a strobe every 4th clk
    run_to(20, 10, 1);
    rec_mode = 0;
    do_reset_check();
    rec_mode = 2;
    for (int i = 0; i < htot * vtot + 4; i++) strobe(4);
    rec_mode = 0;

    // Reset while both syncs are low and vblank is high
    run_to(46, 32, 1);
    do_reset_check();
    for (int i = 0; i < 8; i++) strobe(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
